// File: rtl/sample_collector_if.sv
// Producer-facing handshake of the sample collector: request level out, sample pulses in.
// No latency of its own; pure wiring bundle.
// No backpressure: the producer streams one sample per sample_valid cycle while request_level is high.
interface sample_collector_if #(
   parameter int SAMPLE_WIDTH = 64
);
   logic                    request_level;
   logic                    sample_valid;
   logic [SAMPLE_WIDTH-1:0] sample_data;

   // master is the sample-sequence producer
   modport master (
      input  request_level,
      output sample_valid,
      output sample_data
   );

   // slave is the collector that requests and checks the burst
   modport slave (
      output request_level,
      input  sample_valid,
      input  sample_data
   );
endinterface

// File: rtl/sample_collector.sv
// Requests a burst from the producer, checks it follows 1..SAMPLE_COUNT, reports count/error/sum.
// Start -> request in 1 cycle; sample -> status in 1 cycle; last sample -> done after 1+DRAIN_CYCLES.
// Never stalls the producer; samples arriving while not requesting are flagged as overrun.
// Optional running sum enabled by defining SAMPLE_COLLECTOR_SUM_EN.
module sample_collector #(
   parameter int SAMPLE_COUNT = 64,
   parameter int SAMPLE_WIDTH = 64,
   parameter int TIMEOUT      = 256,
   parameter int DRAIN_CYCLES = 2,
   parameter int COUNT_W      = $clog2(SAMPLE_COUNT + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   sample_collector_if.slave       smp,
   output logic                    busy,
   output logic                    done,
   output logic                    error,
   output logic                    timeout,
   output logic [COUNT_W-1:0]      received_count,
   output logic [COUNT_W-1:0]      mismatch_index,
   output logic [SAMPLE_WIDTH-1:0] sample_sum
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, REQUEST, COLLECT, DRAIN} state_t;

   state_t             state, state_nxt;
   logic [TMO_W-1:0]   tmo_cnt;
   logic [DRN_W-1:0]   drain_cnt;
   logic [COUNT_W-1:0] expected;
   logic               collecting;
   logic               accept;
   logic               mismatch;
   logic               last;
   logic               tmo_fire;
   logic               drain_end;
   logic               overrun;
   logic               start_ok;

   // decode the handshake events used by both the FSM and the status registers
   always_comb begin
      collecting = (state == REQUEST) || (state == COLLECT);
      accept     = collecting && smp.sample_valid;
      expected   = received_count + COUNT_W'(1);
      // expected is zero-extended so the whole sample word must match, not just the low bits
      mismatch   = smp.sample_data != SAMPLE_WIDTH'(expected);
      last       = accept && (expected == COUNT_W'(SAMPLE_COUNT));
      // the counter holds TIMEOUT-1 after TIMEOUT-1 empty cycles, so this empty cycle is the TIMEOUT-th
      tmo_fire   = collecting && !smp.sample_valid && (tmo_cnt == TMO_W'(TIMEOUT - 1));
      drain_end  = (state == DRAIN) && (drain_cnt == DRN_W'(DRAIN_CYCLES - 1));
      overrun    = smp.sample_valid && ((state == IDLE) || (state == DRAIN));
      start_ok   = (state == IDLE) && start;
   end

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = REQUEST;
         REQUEST,
         COLLECT: begin
            if (last || tmo_fire) state_nxt = DRAIN;
            else if (accept)      state_nxt = COLLECT;
         end
         DRAIN:   if (drain_end) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // state-decoded outputs toward the producer and the controller
   always_comb begin
      smp.request_level = collecting;
      busy              = (state != IDLE);
   end

   // status, counters and the done pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         done           <= 1'b0;
         error          <= 1'b0;
         timeout        <= 1'b0;
         received_count <= '0;
         mismatch_index <= '0;
         tmo_cnt        <= '0;
         drain_cnt      <= '0;
      end else begin
         done      <= drain_end;
         drain_cnt <= (state == DRAIN) ? drain_cnt + DRN_W'(1) : '0;
         if (start_ok) begin
            error          <= 1'b0;
            timeout        <= 1'b0;
            received_count <= '0;
            mismatch_index <= '0;
            tmo_cnt        <= '0;
         end
         if (collecting) tmo_cnt <= accept ? '0 : tmo_cnt + TMO_W'(1);
         if (accept) begin
            if (received_count != COUNT_W'(SAMPLE_COUNT)) received_count <= expected;
            if (mismatch) begin
               error <= 1'b1;
               // mismatch_index is never 0 once latched, so 0 means no earlier mismatch
               if (mismatch_index == '0) mismatch_index <= expected;
            end
         end
         if (tmo_fire) begin
            error   <= 1'b1;
            timeout <= 1'b1;
         end
         // placed after the start clear so a stray sample alongside start is still reported
         if (overrun) error <= 1'b1;
      end
   end

`ifdef SAMPLE_COLLECTOR_SUM_EN
   // wrap-around running sum of accepted samples, cleared by an accepted start
   always_ff @(posedge clk) begin
      if (reset)         sample_sum <= '0;
      else if (start_ok) sample_sum <= '0;
      else if (accept)   sample_sum <= sample_sum + smp.sample_data;
   end
`else
   assign sample_sum = '0;
`endif

endmodule
